// File: rtl/multiplier_arbiter_if.sv
// Client-side and multiplier-side signal bundle for multiplier_arbiter.
// The slave modport is the arbiter's view; master is the clients/multiplier view.
interface multiplier_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 3
);
  logic [M-1:0]   req;
  logic [M*N-1:0] req_multiplicand;
  logic [M*N-1:0] req_multiplier;
  logic [M-1:0]   grant;
  logic [M-1:0]   done;
  logic [2*N-1:0] result;
  logic           busy;
  logic           mul_start;
  logic [N-1:0]   mul_multiplicand;
  logic [N-1:0]   mul_multiplier;
  logic [2*N-1:0] mul_product;
  logic           mul_ready;

  modport slave (
    input  req, req_multiplicand, req_multiplier, mul_product, mul_ready,
    output grant, done, result, busy, mul_start, mul_multiplicand, mul_multiplier
  );

  modport master (
    output req, req_multiplicand, req_multiplier, mul_product, mul_ready,
    input  grant, done, result, busy, mul_start, mul_multiplicand, mul_multiplier
  );
endinterface

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one start/ready shift-add multiplier among M
// requesters; latches the winner's operands and returns the product with a done pulse.
module multiplier_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  multiplier_arbiter_if.slave   bus
);

  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;

  logic          found;
  logic [PW-1:0] win;
  logic [N-1:0]  win_a;
  logic [N-1:0]  win_b;
  logic [M-1:0]  win_onehot;
  logic [M-1:0]  owner_onehot;
  logic [PW-1:0] ptr_next;

  // (base + off) mod M, valid because both operands are already below M.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input int unsigned   off);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(off);
    if (s >= (PW+1)'(M))
      s = s - (PW+1)'(M);
    return s[PW-1:0];
  endfunction

  function automatic logic [M-1:0] onehot(input logic [PW-1:0] x);
    logic [M-1:0] o;
    o = '0;
    for (int unsigned i = 0; i < M; i++)
      o[i] = (x == PW'(i));
    return o;
  endfunction

  // Search ptr, ptr+1, ... (mod M); the first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < M; k++) begin
      if (!found && bus.req[wrap_add(ptr, k)]) begin
        found = 1'b1;
        win   = wrap_add(ptr, k);
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (win == PW'(i)) begin
        win_a = bus.req_multiplicand[i*N +: N];
        win_b = bus.req_multiplier[i*N +: N];
      end
    end
  end

  always_comb begin
    win_onehot   = onehot(win);
    owner_onehot = onehot(owner);
    ptr_next     = (win == PW'(M-1)) ? '0 : win + PW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      ptr                  <= '0;
      owner                <= '0;
      bus.grant            <= '0;
      bus.done             <= '0;
      bus.result           <= '0;
      bus.busy             <= 1'b0;
      bus.mul_start        <= 1'b0;
      bus.mul_multiplicand <= '0;
      bus.mul_multiplier   <= '0;
    end else begin
      bus.grant <= '0;
      bus.done  <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.mul_multiplicand <= win_a;
            bus.mul_multiplier   <= win_b;
            owner                <= win;
            bus.grant            <= win_onehot;
            bus.mul_start        <= 1'b1;
            bus.busy             <= 1'b1;
            ptr                  <= ptr_next;
            state                <= WAIT;
          end
        end
        WAIT: begin
          bus.mul_start <= 1'b0;
          // ready seen while start is still high belongs to the previous operation
          if (!bus.mul_start && bus.mul_ready) begin
            bus.result <= bus.mul_product;
            bus.done   <= owner_onehot;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Scoreboard bench for multiplier_arbiter with a behavioural shift-add multiplier.
`timescale 1ns/1ps
module tb_multiplier_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned M = 3;

  logic clock;
  logic reset_n;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  multiplier_arbiter_if #(.N(N), .M(M)) bus ();

  multiplier_arbiter #(.N(N), .M(M)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Shift-add multiplier: loads on start, N steps, ready stays high until next start.
  logic [2*N-1:0] acc, a_sh;
  logic [N-1:0]   b_sh;
  logic           m_ready;
  int unsigned    m_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0; a_sh <= '0; b_sh <= '0; m_ready <= 1'b0; m_cnt <= 0;
    end else if (bus.mul_start) begin
      a_sh    <= {{N{1'b0}}, bus.mul_multiplicand};
      b_sh    <= bus.mul_multiplier;
      acc     <= '0;
      m_cnt   <= N;
      m_ready <= 1'b0;
    end else if (m_cnt != 0) begin
      if (b_sh[0]) acc <= acc + a_sh;
      a_sh  <= a_sh << 1;
      b_sh  <= b_sh >> 1;
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_ready <= 1'b1;
    end
  end

  assign bus.mul_product = acc;
  assign bus.mul_ready   = m_ready;

  typedef struct {
    logic [M-1:0]   who;
    logic [2*N-1:0] val;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    int unsigned    at;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic void push_grant(input int unsigned i, input logic [N-1:0] a,
                                     input logic [N-1:0] b, input int unsigned at);
    exp_t e;
    e.who = '0; e.who[i] = 1'b1; e.val = '0; e.a = a; e.b = b; e.at = at;
    gq.push_back(e);
  endfunction

  function automatic void push_done(input int unsigned i, input logic [2*N-1:0] p,
                                    input int unsigned at);
    exp_t e;
    e.who = '0; e.who[i] = 1'b1; e.val = p; e.a = '0; e.b = '0; e.at = at;
    dq.push_back(e);
  endfunction

  // Monitor: pops expectations whenever the DUT pulses grant or done.
  exp_t ge, de;
  logic prev_start = 1'b0;
  always @(negedge clock) begin
    if (bus.mul_start) chk("start_one_cycle", 32'(prev_start), 32'd0);
    prev_start = bus.mul_start;
    if (bus.grant != '0) begin
      if (gq.size() == 0) begin
        checks++; failures++;
        $display("FAIL grant_unexpected actual=%b required=none", bus.grant);
      end else begin
        ge = gq.pop_front();
        chk("grant_who",   32'(bus.grant), 32'(ge.who));
        chk("grant_cycle", cyc, ge.at);
        chk("grant_start", 32'(bus.mul_start), 32'd1);
        chk("grant_a",     32'(bus.mul_multiplicand), 32'(ge.a));
        chk("grant_b",     32'(bus.mul_multiplier), 32'(ge.b));
      end
    end
    if (bus.done != '0) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected actual=%b required=none", bus.done);
      end else begin
        de = dq.pop_front();
        chk("done_who",    32'(bus.done), 32'(de.who));
        chk("done_cycle",  cyc, de.at);
        chk("done_result", 32'(bus.result), 32'(de.val));
      end
    end
  end

  task automatic at_cyc(input int unsigned t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic set_ops(input int unsigned i, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.req_multiplicand[i*N +: N] = a;
    bus.req_multiplier[i*N +: N]   = b;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_grant"}, 32'(bus.grant), 32'd0);
    chk({nm, "_done"},  32'(bus.done), 32'd0);
    chk({nm, "_result"}, 32'(bus.result), 32'd0);
    chk({nm, "_busy"},  32'(bus.busy), 32'd0);
    chk({nm, "_start"}, 32'(bus.mul_start), 32'd0);
    chk({nm, "_mcand"}, 32'(bus.mul_multiplicand), 32'd0);
    chk({nm, "_mplier"}, 32'(bus.mul_multiplier), 32'd0);
  endtask

  // Single request from an idle arbiter; called and returns at a negedge.
  task automatic op(input int unsigned i, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic [2*N-1:0] p);
    int unsigned c;
    set_ops(i, a, b);
    bus.req[i] = 1'b1;
    c = cyc + 1;
    push_grant(i, a, b, c);
    push_done(i, p, c + N + 2);
    @(negedge clock);
    bus.req[i] = 1'b0;
    chk("op_busy_high", 32'(bus.busy), 32'd1);
    at_cyc(c + N + 2);
    chk("op_busy_low", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int unsigned c0;
    reset_n = 1'b0;
    bus.req = '1;
    bus.req_multiplicand = '0;
    bus.req_multiplier   = '0;
    set_ops(0, 4'd3, 4'd5);
    set_ops(1, 4'd7, 4'd2);
    set_ops(2, 4'd9, 4'd9);
    repeat (3) @(negedge clock);
    check_zero("rst");

    // Round-robin with all three requesting; each drops on grant, re-raises on done.
    reset_n = 1'b1;
    c0 = cyc + 1;
    push_grant(0, 4'd3, 4'd5, c0);      push_done(0, 8'd15, c0 + 6);
    push_grant(1, 4'd7, 4'd2, c0 + 7);  push_done(1, 8'd14, c0 + 13);
    push_grant(2, 4'd9, 4'd9, c0 + 14); push_done(2, 8'd81, c0 + 20);
    push_grant(0, 4'd3, 4'd5, c0 + 21); push_done(0, 8'd15, c0 + 27);
    at_cyc(c0);      bus.req[0] = 1'b0;
    at_cyc(c0 + 6);  bus.req[0] = 1'b1;
    at_cyc(c0 + 7);  bus.req[1] = 1'b0;
    at_cyc(c0 + 13); bus.req[1] = 1'b1;
    at_cyc(c0 + 14); bus.req[2] = 1'b0;
    at_cyc(c0 + 20); bus.req[2] = 1'b1;
    at_cyc(c0 + 21); bus.req = '0;
    at_cyc(c0 + 27);
    chk("rr_busy_low", 32'(bus.busy), 32'd0);

    // Single op, then back-to-back ops on one requester (stale ready).
    op(1, 4'd11, 4'd6, 8'd66);
    op(0, 4'd11, 4'd6, 8'd66);
    op(0, 4'd15, 4'd15, 8'd225);

    // ptr is 1 here; requesters 0 and 2 ask together -> 2 first, then 0.
    set_ops(0, 4'd4, 4'd5);
    set_ops(2, 4'd2, 4'd3);
    bus.req = 3'b101;
    c0 = cyc + 1;
    push_grant(2, 4'd2, 4'd3, c0);     push_done(2, 8'd6, c0 + 6);
    push_grant(0, 4'd4, 4'd5, c0 + 7); push_done(0, 8'd20, c0 + 13);
    at_cyc(c0);     bus.req[2] = 1'b0;
    at_cyc(c0 + 7); bus.req[0] = 1'b0;
    at_cyc(c0 + 13);

    // Reset during WAIT: grant happens, done must never appear.
    set_ops(2, 4'd13, 4'd12);
    bus.req[2] = 1'b1;
    c0 = cyc + 1;
    push_grant(2, 4'd13, 4'd12, c0);
    at_cyc(c0);     bus.req[2] = 1'b0;
    at_cyc(c0 + 3); reset_n = 1'b0;
    @(negedge clock);
    check_zero("midrst");
    repeat (8) @(negedge clock);
    check_zero("midrst_hold");
    reset_n = 1'b1;
    op(1, 4'd13, 4'd12, 8'd156);

    repeat (4) @(negedge clock);
    chk("grant_queue_empty", gq.size(), 32'd0);
    chk("done_queue_empty",  dq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Round-robin arbiter and sequencer that shares one sequential shift-add `multiplier` (parameter N, start/ready handshake) between M requesters. It accepts one operand pair at a time and latches it. It pulses the multiplier's `start` for exactly one cycle and waits for `ready`. It then returns the 2N-bit product to the owning requester with a one-cycle done pulse. It sits between client blocks and the multiplier's `start`, `multiplicand`, `multiplier`, `product` and `ready` ports.

## Interface
- N, default 4: multiplier datapath width in bits; must match the attached multiplier.
- M, default 3: number of requesters, at least 2.
- clock  input  1: single clock, all state updates on posedge.
- reset_n  input  1: asynchronous, active-low reset.
- req  input  M: per-requester request level; requester holds it and its operands until it sees its grant bit.
- req_multiplicand  input  M*N: packed operands; requester i occupies bits [i*N +: N].
- req_multiplier  input  M*N: packed operands, same packing.
- grant  output  M: one-hot, one-cycle pulse; operands of that requester were latched.
- done  output  M: one-hot, one-cycle pulse; `result` is valid for that requester.
- result  output  2N: product of the last completed operation; held until the next completion.
- busy  output  1: high whenever state is not IDLE.
- mul_start  output  1: to multiplier `start`.
- mul_multiplicand  output  N: to multiplier `multiplicand`; stable for the whole operation.
- mul_multiplier  output  N: to multiplier `multiplier`; stable for the whole operation.
- mul_product  input  2N: from multiplier `product`.
- mul_ready  input  1: from multiplier `ready`.

## Operation
- All outputs are registered.
- States:
  - IDLE: no operation in flight.
  - WAIT: operation issued, waiting for the multiplier to finish.
- Priority pointer `ptr` (0..M-1) gives the highest-priority requester. The winner is the first i with req[i]=1, searching ptr, ptr+1, … with wrap modulo M.
- IDLE with any req bit set, at the edge:
  - latch the winner's operands into mul_multiplicand / mul_multiplier;
  - latch the winner index as owner;
  - grant <= onehot(owner), mul_start <= 1, state <= WAIT;
  - ptr <= (owner+1) mod M.
- IDLE with req all zero: no change.
- WAIT:
  - mul_start <= 0 at the first edge.
  - Completion is detected at an edge where mul_start==0 and mul_ready==1. mul_ready is ignored while mul_start==1, because a stale ready from the previous operation may still be high.
  - On completion: result <= mul_product, done <= onehot(owner), state <= IDLE.
- grant and done are cleared the cycle after they are asserted.
- req is ignored outside IDLE, so no second grant goes to a requester still holding req after its grant.
- A requester that drops req before being granted is simply not granted; this is not an error.
- Reset values:
  - state IDLE, ptr 0, owner 0;
  - grant 0, done 0, result 0, busy 0;
  - mul_start 0, mul_multiplicand 0, mul_multiplier 0.
- Reset mid-operation aborts the operation with no done pulse. The multiplier shares the same reset_n.

## Timing
- Edge e0, IDLE with req: grant and mul_start are high during cycle e0..e1.
- The multiplier loads at e1 and completes N shift steps at e2..e(N+1). mul_ready is high after e(N+1).
- The arbiter samples mul_ready at e(N+2). done and result are visible after e(N+2).
- Request-to-done latency is N+2 cycles (6 for N=4).
- The arbiter returns to IDLE after e(N+2). The next grant can occur at e(N+3), so issue interval is N+3 cycles.
- Simultaneous requests are resolved by round-robin; with all M requesting continuously, each is served once per M operations.
- Pointer wrap: a grant to M-1 sets ptr to 0.

## Test plan
- Reset: hold reset_n=0 with req=3'b111 → all outputs 0, busy 0, no grant. Release reset → first grant goes to requester 0.
- Single op, N=4, M=3: req[1]=1 with 11×6 → grant=3'b010 one cycle; mul_start high exactly one cycle; done=3'b010 and result=8'd66 six cycles after the granting edge; busy low afterwards.
- Stale ready: two back-to-back ops on requester 0 (11×6, then 15×15) → second done comes N+2 cycles after its grant with result=8'd225, not the stale 66.
- Round-robin: req=3'b111 held, each requester re-raising req after done → grant order 0,1,2,0 and ptr wraps; operands 3×5, 7×2, 9×9 → results 15, 14, 81 to the matching done bits.
- Priority skip: ptr=1 with req=3'b101 → grant goes to requester 2, then requester 0.
- Reset mid-op: assert reset_n=0 during WAIT → no done pulse, outputs 0. After release, a new request completes normally with correct product.
